// File: rtl/sexpr_pkg.sv
// Shared types and helpers for the S-expression token emitter.
// Consumed by sexpr_emitter and sexpr_fold (fold is built only with SEXPR_CONST_FOLD_EN).
package sexpr_pkg;

    typedef enum logic [2:0] {
        TK_LPAR  = 3'd0,
        TK_RPAR  = 3'd1,
        TK_OP    = 3'd2,
        TK_CONST = 3'd3,
        TK_SIG   = 3'd4
    } tok_kind_e;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        OK_SIG   = 2'd0,
        OK_FALSE = 2'd1,
        OK_TRUE  = 2'd2,
        OK_X     = 2'd3
    } opnd_kind_e;

    typedef enum logic [1:0] {
        CV_FALSE = 2'd0,
        CV_TRUE  = 2'd1,
        CV_X     = 2'd2
    } const_val_e;

    // tok_val carried by OP tokens
    typedef enum logic [1:0] {
        OV_BUS = 2'd0,
        OV_AND = 2'd1,
        OV_OR  = 2'd2,
        OV_XOR = 2'd3
    } op_val_e;

    // FSM encoding kept as plain constants so legacy tools can read it
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_BUS_L  = 4'd1;
    localparam logic [3:0] ST_BUS_OP = 4'd2;
    localparam logic [3:0] ST_G_L    = 4'd3;
    localparam logic [3:0] ST_G_OP   = 4'd4;
    localparam logic [3:0] ST_G_A    = 4'd5;
    localparam logic [3:0] ST_G_B    = 4'd6;
    localparam logic [3:0] ST_G_R    = 4'd7;
    localparam logic [3:0] ST_SINGLE = 4'd8;
    localparam logic [3:0] ST_BUS_R  = 4'd9;

    function automatic op_e op_norm(input logic [1:0] op);
        case (op)
            2'd1:    op_norm = OP_OR;
            2'd2:    op_norm = OP_XOR;
            default: op_norm = OP_AND;
        endcase
    endfunction

    function automatic logic [1:0] op_tok_val(input logic [1:0] op);
        case (op_norm(op))
            OP_OR:   op_tok_val = OV_OR;
            OP_XOR:  op_tok_val = OV_XOR;
            default: op_tok_val = OV_AND;
        endcase
    endfunction

    function automatic logic [1:0] opnd_const(input logic [1:0] kind);
        case (kind)
            OK_TRUE: opnd_const = CV_TRUE;
            OK_X:    opnd_const = CV_X;
            default: opnd_const = CV_FALSE;
        endcase
    endfunction

    function automatic logic [2:0] opnd_tok_kind(input logic [1:0] kind);
        case (kind)
            OK_SIG:  opnd_tok_kind = TK_SIG;
            default: opnd_tok_kind = TK_CONST;
        endcase
    endfunction

endpackage

// File: rtl/sexpr_fold.sv
// Combinational constant-folding decision for one gate record.
// The module exists only when SEXPR_CONST_FOLD_EN is defined.
`ifdef SEXPR_CONST_FOLD_EN
module sexpr_fold
    import sexpr_pkg::*;
#(
    parameter int ID_W = 8
) (
    input  logic [1:0]      i_op,
    input  logic [1:0]      i_a_kind,
    input  logic [ID_W-1:0] i_a_id,
    input  logic [1:0]      i_b_kind,
    input  logic [ID_W-1:0] i_b_id,
    output logic            o_fold,
    output logic [2:0]      o_kind,
    output logic [ID_W-1:0] o_val
);

    logic       w_has_dom;
    logic [1:0] w_dom_kind;
    logic [1:0] w_ident_kind;

    // Dominating and identity constants of the (reserved-normalised) operator
    always_comb begin
        w_has_dom    = 1'b0;
        w_dom_kind   = OK_FALSE;
        w_ident_kind = OK_TRUE;
        case (op_norm(i_op))
            OP_AND: begin
                w_has_dom    = 1'b1;
                w_dom_kind   = OK_FALSE;
                w_ident_kind = OK_TRUE;
            end
            OP_OR: begin
                w_has_dom    = 1'b1;
                w_dom_kind   = OK_TRUE;
                w_ident_kind = OK_FALSE;
            end
            OP_XOR: begin
                w_has_dom    = 1'b0;
                w_dom_kind   = OK_FALSE;
                w_ident_kind = OK_FALSE;
            end
            default: begin
                w_has_dom    = 1'b1;
                w_dom_kind   = OK_FALSE;
                w_ident_kind = OK_TRUE;
            end
        endcase
    end

    // Domination wins over identity; X is never a folding constant itself
    always_comb begin
        o_fold = 1'b0;
        o_kind = TK_LPAR;
        o_val  = '0;
        if (w_has_dom && ((i_a_kind == w_dom_kind) || (i_b_kind == w_dom_kind))) begin
            o_fold = 1'b1;
            o_kind = TK_CONST;
            o_val  = ID_W'(opnd_const(w_dom_kind));
        end else if (i_a_kind == w_ident_kind) begin
            o_fold = 1'b1;
            o_kind = opnd_tok_kind(i_b_kind);
            o_val  = (i_b_kind == OK_SIG) ? i_b_id : ID_W'(opnd_const(i_b_kind));
        end else if (i_b_kind == w_ident_kind) begin
            o_fold = 1'b1;
            o_kind = opnd_tok_kind(i_a_kind);
            o_val  = (i_a_kind == OK_SIG) ? i_a_id : ID_W'(opnd_const(i_a_kind));
        end else begin
            o_fold = 1'b0;
            o_kind = TK_LPAR;
            o_val  = '0;
        end
    end

endmodule
`endif

// File: rtl/sexpr_emitter.sv
// Serialises gate records into a (BUS (OP A B) ...) token stream, one token per handshake.
// Optional constant folding is enabled with SEXPR_CONST_FOLD_EN.
module sexpr_emitter
    import sexpr_pkg::*;
#(
    parameter int ID_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [1:0]      i_in_op,
    input  logic [1:0]      i_in_a_kind,
    input  logic [1:0]      i_in_b_kind,
    input  logic [ID_W-1:0] i_in_a_id,
    input  logic [ID_W-1:0] i_in_b_id,
    input  logic            i_in_last,
    output logic            o_tok_valid,
    input  logic            i_tok_ready,
    output logic [2:0]      o_tok_kind,
    output logic [ID_W-1:0] o_tok_val
);

    logic [3:0]      r_state;
    logic            r_frame_open;
    logic            r_in_ready;
    logic            r_tok_valid;
    logic [2:0]      r_tok_kind;
    logic [ID_W-1:0] r_tok_val;

    logic [1:0]      r_op;
    logic [1:0]      r_a_kind;
    logic [1:0]      r_b_kind;
    logic [ID_W-1:0] r_a_id;
    logic [ID_W-1:0] r_b_id;
    logic            r_last;
    logic            r_fold;
    logic [2:0]      r_fold_kind;
    logic [ID_W-1:0] r_fold_val;

    logic            w_accept;
    logic            w_hs;
    logic [3:0]      w_next;
    logic            w_fold;
    logic [2:0]      w_fold_kind;
    logic [ID_W-1:0] w_fold_val;

    logic [1:0]      w_nx_op;
    logic [1:0]      w_nx_a_kind;
    logic [1:0]      w_nx_b_kind;
    logic [ID_W-1:0] w_nx_a_id;
    logic [ID_W-1:0] w_nx_b_id;
    logic [2:0]      w_nx_fold_kind;
    logic [ID_W-1:0] w_nx_fold_val;
    logic [2:0]      w_tk_kind;
    logic [ID_W-1:0] w_tk_val;

    function automatic logic [ID_W-1:0] opnd_val(input logic [1:0] kind, input logic [ID_W-1:0] id);
        if (kind == OK_SIG) begin
            opnd_val = id;
        end else begin
            opnd_val = ID_W'(opnd_const(kind));
        end
    endfunction

    assign w_accept = i_in_valid && r_in_ready;
    assign w_hs     = r_tok_valid && i_tok_ready;

`ifdef SEXPR_CONST_FOLD_EN
    sexpr_fold #(
        .ID_W (ID_W)
    ) u_fold (
        .i_op     (i_in_op),
        .i_a_kind (i_in_a_kind),
        .i_a_id   (i_in_a_id),
        .i_b_kind (i_in_b_kind),
        .i_b_id   (i_in_b_id),
        .o_fold   (w_fold),
        .o_kind   (w_fold_kind),
        .o_val    (w_fold_val)
    );
`else
    assign w_fold      = 1'b0;
    assign w_fold_kind = 3'd0;
    assign w_fold_val  = '0;
`endif

    // Next state: IDLE waits for a record, every other state waits for a token handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = !r_frame_open ? ST_BUS_L : (w_fold ? ST_SINGLE : ST_G_L);
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_BUS_L:  w_next = w_hs ? ST_BUS_OP : ST_BUS_L;
            ST_BUS_OP: w_next = w_hs ? (r_fold ? ST_SINGLE : ST_G_L) : ST_BUS_OP;
            ST_G_L:    w_next = w_hs ? ST_G_OP : ST_G_L;
            ST_G_OP:   w_next = w_hs ? ST_G_A : ST_G_OP;
            ST_G_A:    w_next = w_hs ? ST_G_B : ST_G_A;
            ST_G_B:    w_next = w_hs ? ST_G_R : ST_G_B;
            ST_G_R,
            ST_SINGLE: w_next = w_hs ? (r_last ? ST_BUS_R : ST_IDLE) : r_state;
            ST_BUS_R:  w_next = w_hs ? ST_IDLE : ST_BUS_R;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Record fields as they will be after this edge, so the token can be registered
    always_comb begin
        if (w_accept) begin
            w_nx_op        = i_in_op;
            w_nx_a_kind    = i_in_a_kind;
            w_nx_b_kind    = i_in_b_kind;
            w_nx_a_id      = i_in_a_id;
            w_nx_b_id      = i_in_b_id;
            w_nx_fold_kind = w_fold_kind;
            w_nx_fold_val  = w_fold_val;
        end else begin
            w_nx_op        = r_op;
            w_nx_a_kind    = r_a_kind;
            w_nx_b_kind    = r_b_kind;
            w_nx_a_id      = r_a_id;
            w_nx_b_id      = r_b_id;
            w_nx_fold_kind = r_fold_kind;
            w_nx_fold_val  = r_fold_val;
        end
    end

    // Token presented in the next state; IDLE drives zeros
    always_comb begin
        w_tk_kind = TK_LPAR;
        w_tk_val  = '0;
        case (w_next)
            ST_BUS_L, ST_G_L: begin
                w_tk_kind = TK_LPAR;
                w_tk_val  = '0;
            end
            ST_BUS_OP: begin
                w_tk_kind = TK_OP;
                w_tk_val  = ID_W'(OV_BUS);
            end
            ST_G_OP: begin
                w_tk_kind = TK_OP;
                w_tk_val  = ID_W'(op_tok_val(w_nx_op));
            end
            ST_G_A: begin
                w_tk_kind = opnd_tok_kind(w_nx_a_kind);
                w_tk_val  = opnd_val(w_nx_a_kind, w_nx_a_id);
            end
            ST_G_B: begin
                w_tk_kind = opnd_tok_kind(w_nx_b_kind);
                w_tk_val  = opnd_val(w_nx_b_kind, w_nx_b_id);
            end
            ST_G_R, ST_BUS_R: begin
                w_tk_kind = TK_RPAR;
                w_tk_val  = '0;
            end
            ST_SINGLE: begin
                w_tk_kind = w_nx_fold_kind;
                w_tk_val  = w_nx_fold_val;
            end
            default: begin
                w_tk_kind = TK_LPAR;
                w_tk_val  = '0;
            end
        endcase
    end

    // Control state and registered output token
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_frame_open <= 1'b0;
            r_in_ready   <= 1'b0;
            r_tok_valid  <= 1'b0;
            r_tok_kind   <= 3'd0;
            r_tok_val    <= '0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == ST_IDLE);
            r_tok_valid <= (w_next != ST_IDLE);
            r_tok_kind  <= w_tk_kind;
            r_tok_val   <= w_tk_val;
            if (w_hs && (r_state == ST_BUS_OP)) begin
                r_frame_open <= 1'b1;
            end else if (w_hs && (r_state == ST_BUS_R)) begin
                r_frame_open <= 1'b0;
            end else begin
                r_frame_open <= r_frame_open;
            end
        end
    end

    // Accepted record is captured whole and held until the next acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= 2'd0;
            r_a_kind    <= 2'd0;
            r_b_kind    <= 2'd0;
            r_a_id      <= '0;
            r_b_id      <= '0;
            r_last      <= 1'b0;
            r_fold      <= 1'b0;
            r_fold_kind <= 3'd0;
            r_fold_val  <= '0;
        end else if (w_accept) begin
            r_op        <= i_in_op;
            r_a_kind    <= i_in_a_kind;
            r_b_kind    <= i_in_b_kind;
            r_a_id      <= i_in_a_id;
            r_b_id      <= i_in_b_id;
            r_last      <= i_in_last;
            r_fold      <= w_fold;
            r_fold_kind <= w_fold_kind;
            r_fold_val  <= w_fold_val;
        end else begin
            r_op        <= r_op;
            r_a_kind    <= r_a_kind;
            r_b_kind    <= r_b_kind;
            r_a_id      <= r_a_id;
            r_b_id      <= r_b_id;
            r_last      <= r_last;
            r_fold      <= r_fold;
            r_fold_kind <= r_fold_kind;
            r_fold_val  <= r_fold_val;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_tok_valid = r_tok_valid;
    assign o_tok_kind  = r_tok_kind;
    assign o_tok_val   = r_tok_val;

endmodule

// File: tb/tb_sexpr_emitter.sv
// Scoreboard bench for sexpr_emitter; expectations follow SEXPR_CONST_FOLD_EN when defined.
module tb_sexpr_emitter;

    localparam int ID_W = 8;
    localparam logic [2:0] K_LPAR = 3'd0, K_RPAR = 3'd1, K_OP = 3'd2, K_CONST = 3'd3, K_SIG = 3'd4;
    localparam logic [1:0] A_SIG = 2'd0, A_F = 2'd1, A_T = 2'd2, A_X = 2'd3;
    localparam logic [1:0] O_AND = 2'd0, O_OR = 2'd1, O_XOR = 2'd2, O_RSV = 2'd3;

    logic            clk;
    logic            rst_n;
    logic            i_in_valid;
    logic            o_in_ready;
    logic [1:0]      i_in_op;
    logic [1:0]      i_in_a_kind;
    logic [1:0]      i_in_b_kind;
    logic [ID_W-1:0] i_in_a_id;
    logic [ID_W-1:0] i_in_b_id;
    logic            i_in_last;
    logic            o_tok_valid;
    logic            i_tok_ready;
    logic [2:0]      o_tok_kind;
    logic [ID_W-1:0] o_tok_val;

    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    sexpr_emitter #(.ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_op     (i_in_op),
        .i_in_a_kind (i_in_a_kind),
        .i_in_b_kind (i_in_b_kind),
        .i_in_a_id   (i_in_a_id),
        .i_in_b_id   (i_in_b_id),
        .i_in_last   (i_in_last),
        .o_tok_valid (o_tok_valid),
        .i_tok_ready (i_tok_ready),
        .o_tok_kind  (o_tok_kind),
        .o_tok_val   (o_tok_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [7:0] v);
        exp_q.push_back({k, v});
    endtask

    task automatic push_opnd(input logic [1:0] kind, input logic [7:0] id);
        case (kind)
            A_SIG:   push(K_SIG, id);
            A_F:     push(K_CONST, 8'd0);
            A_T:     push(K_CONST, 8'd1);
            default: push(K_CONST, 8'd2);
        endcase
    endtask

    task automatic push_gate(input logic [7:0] opv, input logic [1:0] ak, input logic [7:0] aid,
                             input logic [1:0] bk, input logic [7:0] bid);
        push(K_LPAR, 8'd0);
        push(K_OP, opv);
        push_opnd(ak, aid);
        push_opnd(bk, bid);
        push(K_RPAR, 8'd0);
    endtask

    task automatic push_open();
        push(K_LPAR, 8'd0);
        push(K_OP, 8'd0);
    endtask

    // Offers one record; checks that the first token follows on the next cycle
    task automatic send(input logic [1:0] op, input logic [1:0] ak, input logic [7:0] aid,
                        input logic [1:0] bk, input logic [7:0] bid, input logic last);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!o_in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", {31'd0, (n < 200)}, 32'd1);
        i_in_valid  = 1'b1;
        i_in_op     = op;
        i_in_a_kind = ak;
        i_in_a_id   = aid;
        i_in_b_kind = bk;
        i_in_b_id   = bid;
        i_in_last   = last;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        check("first_tok_valid", {31'd0, o_tok_valid}, 32'd1);
        check("ready_low_after_accept", {31'd0, o_in_ready}, 32'd0);
    endtask

    task automatic wait_tok(input logic [2:0] k, input logic [7:0] v);
        int n;
        n = 0;
        while (!(o_tok_valid && o_tok_kind == k && o_tok_val == v) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_tok", {31'd0, (n < 50)}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("idle_tok_valid", {31'd0, o_tok_valid}, 32'd0);
        check("idle_in_ready", {31'd0, o_in_ready}, 32'd1);
    endtask

    // Monitor: every token handshake pops and compares one expected token
    always @(negedge clk) begin
        if (rst_n && o_tok_valid && i_tok_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL token_unexpected: got kind %0d val %0d, expected none", o_tok_kind, o_tok_val);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("token", {21'd0, o_tok_kind, o_tok_val}, {21'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_in_op     = 2'd0;
        i_in_a_kind = 2'd0;
        i_in_b_kind = 2'd0;
        i_in_a_id   = 8'd0;
        i_in_b_id   = 8'd0;
        i_in_last   = 1'b0;
        i_tok_ready = 1'b1;

        #12;
        check("rst_tok_valid", {31'd0, o_tok_valid}, 32'd0);
        check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
        check("rst_tok_kind", {29'd0, o_tok_kind}, 32'd0);
        check("rst_tok_val", {24'd0, o_tok_val}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, o_in_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {31'd0, o_in_ready}, 32'd1);

        // Three AND records sharing one frame
`ifdef SEXPR_CONST_FOLD_EN
        push_open();
        push(K_CONST, 8'd0);
        push(K_SIG, 8'd5);
        push_gate(8'd1, A_SIG, 8'd5, A_X, 8'd0);
        push(K_RPAR, 8'd0);
`else
        push_open();
        push_gate(8'd1, A_SIG, 8'd5, A_F, 8'd0);
        push_gate(8'd1, A_SIG, 8'd5, A_T, 8'd0);
        push_gate(8'd1, A_SIG, 8'd5, A_X, 8'd0);
        push(K_RPAR, 8'd0);
`endif
        send(O_AND, A_SIG, 8'd5, A_F, 8'd0, 1'b0);
        send(O_AND, A_SIG, 8'd5, A_T, 8'd0, 1'b0);
        send(O_AND, A_SIG, 8'd5, A_X, 8'd0, 1'b1);
        drain();

        // Back-pressure on the A operand of an XOR
        push_open();
        push_gate(8'd3, A_SIG, 8'd3, A_SIG, 8'd4);
        push(K_RPAR, 8'd0);
        send(O_XOR, A_SIG, 8'd3, A_SIG, 8'd4, 1'b1);
        wait_tok(K_SIG, 8'd3);
        i_tok_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_valid", {31'd0, o_tok_valid}, 32'd1);
            check("stall_tok", {21'd0, o_tok_kind, o_tok_val}, {21'd0, K_SIG, 8'd3});
            check("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
        end
        i_tok_ready = 1'b1;
        drain();

        // Reset while the B operand of an open frame is pending
        push_open();
        push(K_LPAR, 8'd0);
        push(K_OP, 8'd1);
        push(K_SIG, 8'd1);
        send(O_AND, A_SIG, 8'd1, A_SIG, 8'd2, 1'b0);
        wait_tok(K_SIG, 8'd2);
        i_tok_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tok_valid", {31'd0, o_tok_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, o_in_ready}, 32'd0);
        check("midrst_tok_kind", {29'd0, o_tok_kind}, 32'd0);
        check("partial_consumed", exp_q.size(), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        i_tok_ready = 1'b1;
        push_open();
`ifdef SEXPR_CONST_FOLD_EN
        push(K_SIG, 8'd7);
`else
        push_gate(8'd2, A_F, 8'd0, A_SIG, 8'd7);
`endif
        push(K_RPAR, 8'd0);
        send(O_OR, A_F, 8'd0, A_SIG, 8'd7, 1'b1);
        drain();

        // Folding precedence, X handling and the reserved opcode, one frame each
        push_open();
`ifdef SEXPR_CONST_FOLD_EN
        push(K_CONST, 8'd1);
`else
        push_gate(8'd2, A_T, 8'd0, A_F, 8'd0);
`endif
        push(K_RPAR, 8'd0);
        send(O_OR, A_T, 8'd0, A_F, 8'd0, 1'b1);

        push_open();
`ifdef SEXPR_CONST_FOLD_EN
        push(K_CONST, 8'd2);
`else
        push_gate(8'd1, A_T, 8'd0, A_X, 8'd0);
`endif
        push(K_RPAR, 8'd0);
        send(O_AND, A_T, 8'd0, A_X, 8'd0, 1'b1);

        push_open();
        push_gate(8'd3, A_X, 8'd0, A_X, 8'd0);
        push(K_RPAR, 8'd0);
        send(O_XOR, A_X, 8'd0, A_X, 8'd0, 1'b1);

        push_open();
`ifdef SEXPR_CONST_FOLD_EN
        push(K_CONST, 8'd0);
`else
        push_gate(8'd1, A_SIG, 8'd9, A_F, 8'd0);
`endif
        push(K_RPAR, 8'd0);
        send(O_RSV, A_SIG, 8'd9, A_F, 8'd0, 1'b1);

        push_open();
`ifdef SEXPR_CONST_FOLD_EN
        push(K_SIG, 8'd6);
`else
        push_gate(8'd3, A_SIG, 8'd6, A_F, 8'd0);
`endif
        push(K_RPAR, 8'd0);
        send(O_XOR, A_SIG, 8'd6, A_F, 8'd0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
